// File: rtl/sensor_clock_divider.sv
// -----------------------------------------------------------------------------
// sensor_clock_divider
//
// Purpose:
//   Divides the slow system clock (clk_3M) by an integer ratio to produce the
//   optical sensor's sample clock. It also provides single-cycle edge strobes
//   and a count of sensor_clk rising edges. Readout logic in the clk_3M domain
//   can use these to align to sensor_clk without sampling it as data.
//
// Parameters:
//   DIV_RATIO  clk_3M cycles per sensor_clk period (2..65535)
//   CNT_W      width of sclk_count
//
// Ports:
//   clk_3M      in   system clock, rising-edge logic
//   reset       in   asynchronous active-low reset (0 = in reset)
//   sensor_clk  out  divided clock, driven straight from a flop
//   sclk_rise   out  1-cycle strobe, registered with sensor_clk going 0->1
//   sclk_fall   out  1-cycle strobe, registered with sensor_clk going 1->0
//   sclk_count  out  sensor_clk rising edges since reset, wraps
// -----------------------------------------------------------------------------
module sensor_clock_divider #(
  parameter int DIV_RATIO = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk_3M,
  input  logic             reset,
  output logic             sensor_clk,
  output logic             sclk_rise,
  output logic             sclk_fall,
  output logic [CNT_W-1:0] sclk_count
);

  // The guard keeps PH_W at 1 or more even when DIV_RATIO is illegal. The
  // elaboration check below can then report the error cleanly.
  localparam int PH_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
  localparam int HI   = (DIV_RATIO + 1) / 2;

  localparam logic [PH_W-1:0]  PH_ZERO  = {PH_W{1'b0}};
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DIV_RATIO - 1);
  localparam logic [PH_W-1:0]  PH_HI    = PH_W'(HI);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DIV_RATIO < 2) begin : g_bad_ratio
    $error("sensor_clock_divider: DIV_RATIO must be at least 2");
  end

  logic [PH_W-1:0]  ph_q, ph_d;
  logic             sensor_clk_q, sensor_clk_d;
  logic             sclk_rise_q, sclk_rise_d;
  logic             sclk_fall_q, sclk_fall_d;
  logic [CNT_W-1:0] sclk_count_q, sclk_count_d;

  // Next-state logic. The flops take their values from the current phase, so
  // phase 0 at the first edge after release yields the rise on edge 1. Phase
  // HI yields the fall exactly HI cycles later. The extra cycle for odd ratios
  // therefore falls in the high part of the period.
  always_comb begin
    ph_d         = ph_q;
    sensor_clk_d = sensor_clk_q;
    sclk_rise_d  = 1'b0;
    sclk_fall_d  = 1'b0;
    sclk_count_d = sclk_count_q;

    if (ph_q == PH_LAST) begin
      ph_d = PH_ZERO;
    end else begin
      ph_d = ph_q + PH_ONE;
    end

    sensor_clk_d = (ph_q < PH_HI);
    sclk_rise_d  = (ph_q == PH_ZERO);
    sclk_fall_d  = (ph_q == PH_HI);

    if (sclk_rise_d) begin
      sclk_count_d = sclk_count_q + CNT_ONE;
    end else begin
      sclk_count_d = sclk_count_q;
    end
  end

  // State and output registers. Reset clears everything at once and cancels
  // any strobe in progress.
  always_ff @(posedge clk_3M or negedge reset) begin
    if (!reset) begin
      ph_q         <= PH_ZERO;
      sensor_clk_q <= 1'b0;
      sclk_rise_q  <= 1'b0;
      sclk_fall_q  <= 1'b0;
      sclk_count_q <= CNT_ZERO;
    end else begin
      ph_q         <= ph_d;
      sensor_clk_q <= sensor_clk_d;
      sclk_rise_q  <= sclk_rise_d;
      sclk_fall_q  <= sclk_fall_d;
      sclk_count_q <= sclk_count_d;
    end
  end

  assign sensor_clk = sensor_clk_q;
  assign sclk_rise  = sclk_rise_q;
  assign sclk_fall  = sclk_fall_q;
  assign sclk_count = sclk_count_q;

endmodule

// File: tb/tb_sensor_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_sensor_clock_divider
//
// Purpose:
//   Tests three divider instances (N=8, N=7, N=2 with a 4-bit counter). They
//   share one clock and one reset. A reference process counts edges since
//   release and derives the expected outputs arithmetically, pushing them into
//   per-instance queues. A monitor pops and compares after every clock edge
//   and after every reset assertion.
// -----------------------------------------------------------------------------
module tb_sensor_clock_divider;

  typedef struct packed {
    logic        sclk;
    logic        rise;
    logic        fall;
    logic [15:0] cnt;
  } exp_t;

  logic clk_3M = 1'b0;
  logic reset  = 1'b0;

  logic        sclk8, rise8, fall8;
  logic [15:0] cnt8;
  logic        sclk7, rise7, fall7;
  logic [15:0] cnt7;
  logic        sclk2, rise2, fall2;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  exp_t q8[$];
  exp_t q7[$];
  exp_t q2[$];

  sensor_clock_divider #(.DIV_RATIO(8), .CNT_W(16)) dut8 (
    .clk_3M(clk_3M), .reset(reset), .sensor_clk(sclk8),
    .sclk_rise(rise8), .sclk_fall(fall8), .sclk_count(cnt8)
  );

  sensor_clock_divider #(.DIV_RATIO(7), .CNT_W(16)) dut7 (
    .clk_3M(clk_3M), .reset(reset), .sensor_clk(sclk7),
    .sclk_rise(rise7), .sclk_fall(fall7), .sclk_count(cnt7)
  );

  sensor_clock_divider #(.DIV_RATIO(2), .CNT_W(4)) dut2 (
    .clk_3M(clk_3M), .reset(reset), .sensor_clk(sclk2),
    .sclk_rise(rise2), .sclk_fall(fall2), .sclk_count(cnt2)
  );

  // 250 ns clock period
  always #125 clk_3M = ~clk_3M;

  // Expected outputs after edge k since release (k=0 means in reset).
  function automatic exp_t model(int k, int n, int w);
    exp_t e;
    int   p;
    int   hi;
    e  = '0;
    hi = (n + 1) / 2;
    if (k > 0) begin
      p      = (k - 1) % n;
      e.sclk = (p < hi);
      e.rise = (p == 0);
      e.fall = (p == hi);
      e.cnt  = 16'((((k - 1) / n) + 1) % (1 << w));
    end
    return e;
  endfunction

  task automatic compare(string name, exp_t e, logic s, logic r, logic f,
                         logic [15:0] c);
    checks++;
    if ({s, r, f, c} !== {e.sclk, e.rise, e.fall, e.cnt}) begin
      errors++;
      $display("FAIL %s @%0t: got clk=%b rise=%b fall=%b cnt=%0d, want clk=%b rise=%b fall=%b cnt=%0d",
               name, $time, s, r, f, c, e.sclk, e.rise, e.fall, e.cnt);
    end
  endtask

  // Reference: count edges since release and queue the expected outputs.
  initial begin : reference
    int k;
    k = 0;
    forever begin
      @(posedge clk_3M or negedge reset);
      if (!reset) begin
        k = 0;
      end else begin
        k = k + 1;
      end
      q8.push_back(model(k, 8, 16));
      q7.push_back(model(k, 7, 16));
      q2.push_back(model(k, 2, 4));
    end
  end

  // Monitor: sample shortly after each edge or reset assertion and compare.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_3M or negedge reset);
      #1;
      if (q8.size() == 0 || q7.size() == 0 || q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL queue_empty @%0t: got no expected entry, want one per event", $time);
      end else begin
        e = q8.pop_front();
        compare("n8", e, sclk8, rise8, fall8, cnt8);
        e = q7.pop_front();
        compare("n7", e, sclk7, rise7, fall7, cnt7);
        e = q2.pop_front();
        compare("n2", e, sclk2, rise2, fall2, {12'd0, cnt2});
      end
    end
  end

  // Stimulus: power-up reset, a long run, then randomized mid-period resets.
  initial begin : stimulus
    bit found;
    #150;
    reset = 1'b1;
    // Over 100 periods of N=8, plus wraps of the 4-bit counter
    repeat (805) @(negedge clk_3M);

    for (int i = 0; i < 6; i++) begin
      // Wait, with a bound, for the N=8 output to be high. Then reset it
      // mid-cycle.
      found = 1'b0;
      for (int j = 0; j < 20 && !found; j++) begin
        @(negedge clk_3M);
        if (sclk8) found = 1'b1;
      end
      if (!found) begin
        checks++;
        errors++;
        $display("FAIL wait_high: got sensor_clk stuck low for 20 cycles, want high within 8");
      end
      #($urandom_range(1, 100));
      reset = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk_3M);
      reset = 1'b1;
      repeat ($urandom_range(17, 60)) @(negedge clk_3M);
    end

    repeat (2) @(negedge clk_3M);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
